// File: rtl/hazard_pause_ctrl.sv
// ============================================================================
// Module   : hazard_pause_ctrl
// Purpose  : Pause/clear strobes for the five-stage CPU pipeline (load-use,
//            shared-RAM fetch conflict, memory wait, taken jump).
//            Optional macro HAZARD_STALL_CNT_EN enables the stall counter.
// Revision : 1.0
// ============================================================================
`default_nettype none

`ifndef PAUSE_ENABLE
`define PAUSE_ENABLE 1'b1
`endif

module hazard_pause_ctrl #(
    parameter int REG_ID_W    = 4,
    parameter int MEM_TIMEOUT = 64
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [REG_ID_W-1:0] id_src_a,
    input  logic                id_src_a_used,
    input  logic [REG_ID_W-1:0] id_src_b,
    input  logic                id_src_b_used,
    input  logic                exe_load,
    input  logic [REG_ID_W-1:0] exe_dst,
    input  logic                exe_wb_en,
    input  logic                exe_jump_en,
    input  logic                mem_if_conflict,
    input  logic                mem_busy,
    output logic                PC_PAUSE,
    output logic                IF_ID_PAUSE,
    output logic                ID_EXE_PAUSE,
    output logic                EXE_MEM_PAUSE,
    output logic                IF_ID_CLEAR,
    output logic                ID_EXE_CLEAR,
    output logic                mem_timeout,
    output logic [15:0]         stall_cnt
);

    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] c_TO_LAST = CNT_W'(MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_to_cnt;
    logic             w_load_use;

    assign w_load_use = exe_load & exe_wb_en &
                        ((id_src_a_used & (id_src_a == exe_dst)) |
                         (id_src_b_used & (id_src_b == exe_dst)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Counter only runs while the RAM is busy; any idle cycle restarts it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_to_cnt <= '0;
        end else if (mem_busy) begin
            r_to_cnt <= (r_to_cnt == c_TO_LAST) ? '0 : r_to_cnt + 1'b1;
        end else begin
            r_to_cnt <= '0;
        end
    end

    always_comb begin
        w_state_nxt   = RUN;
        PC_PAUSE      = 1'b0;
        IF_ID_PAUSE   = 1'b0;
        ID_EXE_PAUSE  = 1'b0;
        EXE_MEM_PAUSE = 1'b0;
        IF_ID_CLEAR   = 1'b0;
        ID_EXE_CLEAR  = 1'b0;
        mem_timeout   = 1'b0;
        if (!rst) begin
            IF_ID_CLEAR  = `PAUSE_ENABLE;
            ID_EXE_CLEAR = `PAUSE_ENABLE;
        end else if (mem_busy) begin
            PC_PAUSE      = `PAUSE_ENABLE;
            IF_ID_PAUSE   = `PAUSE_ENABLE;
            ID_EXE_PAUSE  = `PAUSE_ENABLE;
            EXE_MEM_PAUSE = `PAUSE_ENABLE;
            mem_timeout   = (r_to_cnt == c_TO_LAST);
            w_state_nxt   = MEM_WAIT;
        end else if (exe_jump_en) begin
            IF_ID_CLEAR  = `PAUSE_ENABLE;
            ID_EXE_CLEAR = `PAUSE_ENABLE;
        end else if ((r_state != LOAD_STALL) && w_load_use) begin
            // EXE holds the bubble next cycle, so the stall never repeats.
            PC_PAUSE     = `PAUSE_ENABLE;
            IF_ID_PAUSE  = `PAUSE_ENABLE;
            ID_EXE_CLEAR = `PAUSE_ENABLE;
            w_state_nxt  = LOAD_STALL;
        end else if (mem_if_conflict) begin
            PC_PAUSE    = `PAUSE_ENABLE;
            IF_ID_CLEAR = `PAUSE_ENABLE;
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= 16'h0000;
        end else if (PC_PAUSE && (r_stall_cnt != 16'hFFFF)) begin
            r_stall_cnt <= r_stall_cnt + 16'h0001;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 16'h0000;
`endif

endmodule

`default_nettype wire
